// File: rtl/dfdd_divider_arbiter.sv
// dfdd_divider_arbiter: round-robin sharing of one external FP divider among NUM_REQ
// requesters, with a tag pipeline that returns col/row/id alongside each quotient. Rev 1.0
`default_nettype none

module dfdd_divider_arbiter #(
  parameter int EXP_WIDTH   = 8,
  parameter int FRAC_WIDTH  = 23,
  parameter int NUM_REQ     = 4,
  parameter int DIV_LATENCY = 10,
  localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH,
  localparam int ID_WIDTH     = $clog2(NUM_REQ)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ*FP_WIDTH_REG-1:0] req_a_i,
  input  logic [NUM_REQ*FP_WIDTH_REG-1:0] req_b_i,
  input  logic [NUM_REQ*16-1:0]           req_col_i,
  input  logic [NUM_REQ*16-1:0]           req_row_i,
  output logic [FP_WIDTH_REG-1:0]         div_a_o,
  output logic [FP_WIDTH_REG-1:0]         div_b_o,
  output logic                            div_valid_o,
  input  logic [FP_WIDTH_REG-1:0]         div_fp_i,
  input  logic                            div_valid_i,
  output logic [FP_WIDTH_REG-1:0]         res_fp_o,
  output logic [15:0]                     res_col_o,
  output logic [15:0]                     res_row_o,
  output logic [ID_WIDTH-1:0]             res_id_o,
  output logic [NUM_REQ-1:0]              res_valid_o,
  output logic                            err_o
);

  logic [ID_WIDTH-1:0] r_ptr;
  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_WIDTH-1:0] w_grant_idx;
  logic [ID_WIDTH-1:0] w_idx;
  logic                w_xfer;

  // Stage 0 sits beside the issue register; stage DIV_LATENCY lines up with div_valid_i.
  logic                r_tag_v   [0:DIV_LATENCY];
  logic [ID_WIDTH-1:0] r_tag_id  [0:DIV_LATENCY];
  logic [15:0]         r_tag_col [0:DIV_LATENCY];
  logic [15:0]         r_tag_row [0:DIV_LATENCY];

  // Search starts just after the last winner, so the last winner has lowest priority.
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_idx       = '0;
    w_xfer      = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = ID_WIDTH'((int'(r_ptr) + i) % NUM_REQ);
      if (!w_xfer && req_valid_i[w_idx]) begin
        w_xfer         = 1'b1;
        w_grant[w_idx] = 1'b1;
        w_grant_idx    = w_idx;
      end
    end
  end

  assign req_ready_o = w_grant;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ptr       <= ID_WIDTH'(NUM_REQ - 1);
      div_a_o     <= '0;
      div_b_o     <= '0;
      div_valid_o <= 1'b0;
      for (int s = 0; s <= DIV_LATENCY; s++) begin
        r_tag_v[s]   <= 1'b0;
        r_tag_id[s]  <= '0;
        r_tag_col[s] <= '0;
        r_tag_row[s] <= '0;
      end
      res_fp_o    <= '0;
      res_col_o   <= '0;
      res_row_o   <= '0;
      res_id_o    <= '0;
      res_valid_o <= '0;
      err_o       <= 1'b0;
    end else begin
      div_valid_o <= w_xfer;
      r_tag_v[0]  <= w_xfer;
      if (w_xfer) begin
        r_ptr        <= w_grant_idx;
        div_a_o      <= req_a_i[w_grant_idx*FP_WIDTH_REG +: FP_WIDTH_REG];
        div_b_o      <= req_b_i[w_grant_idx*FP_WIDTH_REG +: FP_WIDTH_REG];
        r_tag_id[0]  <= w_grant_idx;
        r_tag_col[0] <= req_col_i[w_grant_idx*16 +: 16];
        r_tag_row[0] <= req_row_i[w_grant_idx*16 +: 16];
      end
      for (int s = 1; s <= DIV_LATENCY; s++) begin
        r_tag_v[s]   <= r_tag_v[s-1];
        r_tag_id[s]  <= r_tag_id[s-1];
        r_tag_col[s] <= r_tag_col[s-1];
        r_tag_row[s] <= r_tag_row[s-1];
      end
      res_fp_o    <= div_fp_i;
      res_col_o   <= r_tag_col[DIV_LATENCY];
      res_row_o   <= r_tag_row[DIV_LATENCY];
      res_id_o    <= r_tag_id[DIV_LATENCY];
      res_valid_o <= div_valid_i ? (NUM_REQ'(1) << r_tag_id[DIV_LATENCY]) : '0;
      if (div_valid_i != r_tag_v[DIV_LATENCY]) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dfdd_divider_arbiter.sv
// tb_dfdd_divider_arbiter: directed table plus corner sequences and a random run
// against a scoreboard, with a behavioural divider model. Rev 1.0
`default_nettype none

module tb_dfdd_divider_arbiter;

  localparam int NR  = 4;
  localparam int LAT = 10;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_ready_o;
  logic [127:0]  req_a = '0, req_b = '0;
  logic [63:0]   req_col = '0, req_row = '0;
  logic [31:0]   div_a_o, div_b_o, div_fp_i, res_fp_o;
  logic          div_valid_o, div_valid_i, err_o;
  logic [15:0]   res_col_o, res_row_o;
  logic [1:0]    res_id_o;
  logic [NR-1:0] res_valid_o;
  logic          inject = 1'b0;
  logic          sb_en = 1'b1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] col;
    logic [15:0] row;
    logic [31:0] q;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [3:0] valid;
    logic [3:0] ready;
  } vec_t;
  vec_t tbl [10];

  always #5 clk = ~clk;

  dfdd_divider_arbiter #(
    .EXP_WIDTH(8), .FRAC_WIDTH(23), .NUM_REQ(NR), .DIV_LATENCY(LAT)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_a_i(req_a), .req_b_i(req_b), .req_col_i(req_col), .req_row_i(req_row),
    .div_a_o(div_a_o), .div_b_o(div_b_o), .div_valid_o(div_valid_o),
    .div_fp_i(div_fp_i), .div_valid_i(div_valid_i),
    .res_fp_o(res_fp_o), .res_col_o(res_col_o), .res_row_o(res_row_o),
    .res_id_o(res_id_o), .res_valid_o(res_valid_o), .err_o(err_o)
  );

  function automatic logic [63:0] s2d(input logic [31:0] x);
    return {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'b0};
  endfunction

  // Truncating single-precision divide via double precision; exact for 3.0/2.0.
  function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
    real ra, rb;
    logic [63:0] d;
    ra = $bitstoreal(s2d(a));
    rb = $bitstoreal(s2d(b));
    d  = $realtobits(ra / rb);
    return {d[63], 8'(int'(d[62:52]) - 896), d[51:29]};
  endfunction

  logic        mv [0:LAT-1];
  logic [31:0] mq [0:LAT-1];
  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < LAT; i++) begin
        mv[i] <= 1'b0;
        mq[i] <= '0;
      end
    end else begin
      mv[0] <= div_valid_o;
      mq[0] <= fdiv(div_a_o, div_b_o);
      for (int i = 1; i < LAT; i++) begin
        mv[i] <= mv[i-1];
        mq[i] <= mq[i-1];
      end
    end
  end
  assign div_valid_i = mv[LAT-1] | inject;
  assign div_fp_i    = mq[LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] col, input logic [15:0] row);
    req_a[k*32 +: 32]   = a;
    req_b[k*32 +: 32]   = b;
    req_col[k*16 +: 16] = col;
    req_row[k*16 +: 16] = row;
  endtask

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Negedge monitor: multi-hot check, result scoreboard, transfer capture.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    if (!rst_i) begin
      sbq.delete();
      return;
    end
    cyc++;
    total++;
    if ($countones(req_ready_o) > 1) begin
      bad++;
      $display("FAIL onehot: ready=%b", req_ready_o);
    end
    if (sb_en) begin
      if (sbq.size() > 0 && sbq[0].cyc + LAT + 2 < cyc) begin
        total++;
        bad++;
        $display("FAIL missing: id=%0d issued cyc=%0d now=%0d", sbq[0].id, sbq[0].cyc, cyc);
        void'(sbq.pop_front());
      end
      if (res_valid_o != '0) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL unexpected: res_valid=%b id=%0d", res_valid_o, res_id_o);
        end else begin
          e = sbq.pop_front();
          if (res_valid_o !== (4'b1 << e.id) || res_id_o !== e.id || res_col_o !== e.col ||
              res_row_o !== e.row || res_fp_o !== e.q || cyc != e.cyc + LAT + 2) begin
            bad++;
            $display("FAIL result: got v=%b id=%0d col=%0d row=%0d q=%h cyc=%0d want id=%0d col=%0d row=%0d q=%h cyc=%0d",
                     res_valid_o, res_id_o, res_col_o, res_row_o, res_fp_o, cyc,
                     e.id, e.col, e.row, e.q, e.cyc + LAT + 2);
          end
        end
      end
    end
    for (int k = 0; k < NR; k++) begin
      if (req_valid[k] && req_ready_o[k]) begin
        e.id  = 2'(k);
        e.col = req_col[k*16 +: 16];
        e.row = req_row[k*16 +: 16];
        e.q   = fdiv(req_a[k*32 +: 32], req_b[k*32 +: 32]);
        e.cyc = cyc;
        sbq.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      next_cycle();
      req_valid = '0;
      sample();
    end
  endtask

  task automatic reset_assert();
    next_cycle();
    rst_i     = 1'b0;
    req_valid = '0;
    inject    = 1'b0;
    sbq.delete();
    #2;
  endtask

  task automatic reset_release();
    @(posedge clk);
    #3;
    rst_i = 1'b1;
    sb_en = 1'b1;
  endtask

  initial begin
    logic [3:0] pending;
    int cnt0, cnt2, tcyc;

    tbl[0] = '{4'b0000, 4'b0000};
    tbl[1] = '{4'b0101, 4'b0001};
    tbl[2] = '{4'b0101, 4'b0100};
    tbl[3] = '{4'b1111, 4'b1000};
    tbl[4] = '{4'b0110, 4'b0010};
    tbl[5] = '{4'b0010, 4'b0010};
    tbl[6] = '{4'b1001, 4'b1000};
    tbl[7] = '{4'b1000, 4'b1000};
    tbl[8] = '{4'b0000, 4'b0000};
    tbl[9] = '{4'b0111, 4'b0001};

    for (int k = 0; k < NR; k++)
      set_req(k, 32'h40400000 + 32'(k << 20), 32'h40000000, 16'(10 + k), 16'(20 + k));

    #2;
    check("reset_outputs", {div_valid_o, res_valid_o, err_o, req_ready_o, res_fp_o}, '0);
    reset_release();
    @(negedge clk);

    // Directed arbitration table from reset (ptr starts at NUM_REQ-1)
    foreach (tbl[i]) begin
      next_cycle();
      req_valid = tbl[i].valid;
      sample();
      check($sformatf("tbl%0d_ready", i), 64'(req_ready_o), 64'(tbl[i].ready));
    end
    idle(LAT + 4);

    // Single request: 3.0 / 2.0 from requester 1
    next_cycle();
    set_req(1, 32'h40400000, 32'h40000000, 16'd5, 16'd7);
    req_valid = 4'b0010;
    sample();
    check("single_grant", 64'(req_ready_o), 64'(4'b0010));
    tcyc = cyc;
    idle(LAT + 1);
    check("single_early", 64'(res_valid_o), 64'(0));
    idle(1);
    check("single_lat", 64'(cyc - tcyc), 64'(LAT + 2));
    check("single_res", {res_valid_o, res_fp_o, res_col_o, res_row_o, res_id_o},
          {4'b0010, 32'h3FC00000, 16'd5, 16'd7, 2'd1});
    idle(2);

    // All four valid from reset: grants 0,1,2,3 on consecutive cycles
    reset_assert();
    reset_release();
    for (int k = 0; k < NR; k++) set_req(k, rnd_fp(), rnd_fp(), 16'(100 + k), 16'(200 + k));
    pending = 4'b1111;
    for (int k = 0; k < NR; k++) begin
      next_cycle();
      req_valid = pending;
      sample();
      check($sformatf("all4_grant%0d", k), 64'(req_ready_o), 64'(4'b1 << k));
      pending &= ~req_ready_o;
    end
    idle(LAT + 4);

    // Requesters 0 and 2 contending for 20 cycles
    reset_assert();
    reset_release();
    cnt0 = 0;
    cnt2 = 0;
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      req_valid = 4'b0101;
      sample();
      check($sformatf("alt%0d", i), 64'(req_ready_o), 64'((i % 2) ? 4'b0100 : 4'b0001));
      if (req_ready_o[0]) cnt0++;
      if (req_ready_o[2]) cnt2++;
    end
    check("alt_counts", {32'(cnt0), 32'(cnt2)}, {32'd10, 32'd10});
    idle(LAT + 4);

    // Reset with three requests in flight
    pending = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      req_valid = pending;
      sample();
      pending &= ~req_ready_o;
    end
    idle(3);
    reset_assert();
    check("rst_flight_outs", {div_valid_o, res_valid_o, err_o, req_ready_o, res_id_o,
                              res_col_o, res_row_o}, '0);
    check("rst_flight_fp", {div_a_o, res_fp_o}, '0);
    reset_release();
    idle(LAT + 6);
    check("rst_flight_err", 64'(err_o), 64'(0));
    next_cycle();
    req_valid = 4'b1111;
    sample();
    check("rst_next_grant", 64'(req_ready_o), 64'(4'b0001));
    idle(LAT + 4);

    // Spurious divider valid with nothing issued
    next_cycle();
    sb_en  = 1'b0;
    inject = 1'b1;
    sample();
    check("spur_err_before", 64'(err_o), 64'(0));
    next_cycle();
    inject = 1'b0;
    sample();
    check("spur_err_set", 64'(err_o), 64'(1));
    idle(6);
    check("spur_err_held", 64'(err_o), 64'(1));
    reset_assert();
    check("spur_err_cleared", 64'(err_o), 64'(0));
    reset_release();
    @(negedge clk);

    // Random traffic against the scoreboard
    for (int i = 0; i < 10000; i++) begin
      next_cycle();
      for (int k = 0; k < NR; k++)
        set_req(k, rnd_fp(), rnd_fp(), 16'($urandom), 16'($urandom));
      req_valid = 4'($urandom_range(0, 15));
      sample();
    end
    idle(LAT + 6);
    check("drain_empty", 64'(sbq.size()), 64'(0));
    check("final_err", 64'(err_o), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dfdd_divider_arbiter.md
# dfdd_divider_arbiter

Round-robin arbiter that time-shares one `floating_point_divider` pipeline between `NUM_REQ` divide requesters, such as the per-scale V/W and C/w_t divides of the multi-scale DFDD path. Each granted request's col/row/requester-ID travels alongside the operands in an internal tag pipeline matched to the divider latency. Each result is returned with its original col/row and a one-hot valid, so no separate `floating_point_divider_z` delay lines are needed. The divider is instantiated outside this block and connected through the `div_*` ports.

## Interface
- `EXP_WIDTH`, 8: exponent width of the FP format.
- `FRAC_WIDTH`, 23: fraction width of the FP format.
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DIV_LATENCY`, 10: cycles from `div_valid_o` high to the matching `div_valid_i` high, ≥1.
- `FP_WIDTH_REG` (local): 1+EXP_WIDTH+FRAC_WIDTH.
- `ID_WIDTH` (local): $clog2(NUM_REQ).
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-low.
- `req_valid_i`  in  NUM_REQ  request valid, one bit per requester.
- `req_ready_o`  out  NUM_REQ  grant; one-hot or zero.
- `req_a_i`  in  NUM_REQ*FP_WIDTH_REG  dividends, packed; requester k in slice k.
- `req_b_i`  in  NUM_REQ*FP_WIDTH_REG  divisors, packed.
- `req_col_i`, `req_row_i`  in  NUM_REQ*16 each  pixel coordinates, packed.
- `div_a_o`, `div_b_o`  out  FP_WIDTH_REG each  divider operands.
- `div_valid_o`  out  1  divider issue valid.
- `div_fp_i`  in  FP_WIDTH_REG  divider quotient.
- `div_valid_i`  in  1  divider result valid.
- `res_fp_o`  out  FP_WIDTH_REG  quotient.
- `res_col_o`, `res_row_o`  out  16 each  coordinates carried with the request.
- `res_id_o`  out  ID_WIDTH  index of the requester that issued it.
- `res_valid_o`  out  NUM_REQ  one-hot result valid.
- `err_o`  out  1  sticky tag/divider misalignment flag.

## Operation
- Transfer rule: a request from requester k transfers when `req_valid_i[k]` and `req_ready_o[k]` are both high in the same cycle.
- Arbitration:
  - `req_ready_o` is combinational from `req_valid_i` and the priority pointer `ptr`.
  - Grant goes to the first valid requester searching `ptr+1`, `ptr+2`, … modulo NUM_REQ.
  - At most one grant per cycle. No valid requesters gives no grant.
- Pointer update: on a transfer, `ptr` ← granted index. With no transfer, `ptr` holds.
  - Wrap-around: after index NUM_REQ-1, search continues from 0.
- Fairness: a continuously-asserting requester waits at most NUM_REQ-1 cycles.
- Issue register: on a transfer, the block registers `div_a_o`/`div_b_o` ← slice k, `div_valid_o` ← 1, and the tag {k, col, row} into tag stage 0.
  - With no transfer, `div_valid_o` ← 0, the operand registers hold, and the tag valid bit is 0.
- Tag pipeline: DIV_LATENCY-stage shift register of {valid, id, col, row}, advancing every cycle with no stall. Its output aligns with `div_valid_i`.
- Result register, updated each cycle:
  - `res_fp_o` ← `div_fp_i`; col/row/id ← tag output.
  - `res_valid_o` ← one-hot(id) if `div_valid_i`, else 0.
- Misalignment: if `div_valid_i` ≠ tag-output valid in any cycle, `err_o` sets and stays set until reset.
  - `res_valid_o` still follows `div_valid_i`.
- No output backpressure: consumers must accept a result in the cycle it is presented.
- Reset: all tags, `ptr` = NUM_REQ-1 (so requester 0 has first priority), and all outputs are 0.
  - In-flight requests are discarded.
  - Divider results arriving after reset carry tag valid 0, so they set `err_o` unless the divider was reset together with this block.

## Timing
- Transfer in cycle t gives `div_valid_o` high in t+1 and `div_valid_i` in t+1+DIV_LATENCY.
  - `res_valid_o` is high in t+2+DIV_LATENCY. End-to-end latency is DIV_LATENCY+2.
- Throughput: one divide per cycle aggregate; each requester gets ≥1/NUM_REQ under full contention.
- Results leave in grant order; there is no reordering.
- Simultaneous events: a transfer and a result in the same cycle are independent; both are handled.
- `err_o` asserts one cycle after the mismatching cycle.

## Test plan
- Single request, NUM_REQ=4, DIV_LATENCY=10:
  - Stimulus: requester 1 sends a=0x40400000 (3.0), b=0x40000000 (2.0), col=5, row=7 at cycle t.
  - Required: `res_valid_o`=4'b0010 at t+12, `res_fp_o`=0x3FC00000, col=5, row=7, id=1.
- All four requesters valid from reset, one request each:
  - Required: grants in order 0,1,2,3 on consecutive cycles; results on consecutive cycles with ids 0,1,2,3 and matching col/row.
- Requesters 0 and 2 held valid continuously for 20 cycles:
  - Required: grants alternate 0,2,0,2…; each gets 10 grants.
  - Wrap case: with `ptr`=3, requester 0 must win over 2.
- Reset pulsed with 3 requests in flight (divider also reset):
  - Required: all outputs 0 immediately; no `res_valid_o` afterwards; `err_o`=0; next grant goes to requester 0.
- Bench divider model injects a spurious `div_valid_i` with no issued request:
  - Required: `err_o`=1 the next cycle and held until reset.
- Random valid patterns for 10k cycles against a reference model:
  - Required: every issued request returns exactly once with correct id/col/row/quotient, and `req_ready_o` is never multi-hot.
